// File: rtl/la_cellbist_pkg.sv
// Shared types and constants for the cell self-test harness: FSM state
// encoding, default MISR polynomials per signature width and the MISR seed.
package la_cellbist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]  POLY8     = 8'h07;
    localparam logic [15:0] POLY16    = 16'h1021;
    localparam logic [31:0] POLY32    = 32'h04C1_1DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

    function automatic logic [31:0] default_poly(input int w);
        if (w <= 8)       return {24'd0, POLY8};
        else if (w <= 16) return {16'd0, POLY16};
        else              return POLY32;
    endfunction

endpackage

// File: rtl/la_misr.sv
// Serial-input Galois MISR: shifts left, folds POLY in when the MSB falls
// out, and XORs the 1-bit input into bit 0. Clear reloads the all-ones seed.
module la_misr
    import la_cellbist_pkg::*;
#(
    parameter int              SIGW = 16,
    parameter logic [SIGW-1:0] POLY = SIGW'(default_poly(SIGW))
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            clr,
    input  logic            en,
    input  logic            din,
    output logic [SIGW-1:0] sig
);

    logic [SIGW-1:0] sig_q;
    logic [SIGW-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = MISR_SEED[SIGW-1:0];
        end else if (en) begin
            // din is not masked: an unknown cell output must poison the signature
            sig_d = {sig_q[SIGW-2:0], 1'b0}
                  ^ (sig_q[SIGW-1] ? POLY : '0)
                  ^ {{(SIGW-1){1'b0}}, din};
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) sig_q <= MISR_SEED[SIGW-1:0];
        else         sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/la_cellbist.sv
// Exhaustive-sweep BIST wrapper for a combinational or pipelined cell.
// state | meaning
// IDLE  | after reset, waiting for start
// APPLY | driving stim 0..2**N-1, one vector per cycle
// FLUSH | waiting CAPLAT cycles for the last responses to be captured
// DONE  | first cycle registers done/pass, then holds until next start
module la_cellbist
    import la_cellbist_pkg::*;
#(
    parameter int              N      = 5,
    parameter int              CAPLAT = 0,
    parameter int              SIGW   = 16,
    parameter logic [SIGW-1:0] POLY   = SIGW'(default_poly(SIGW)),
    parameter                  PROP   = "DEFAULT"
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            start,
    input  logic [SIGW-1:0] expected,
    output logic [N-1:0]    stim,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [SIGW-1:0] signature
);

    localparam int           VD        = (CAPLAT == 0) ? 1 : CAPLAT;
    localparam int           CNT_W     = 2;
    localparam logic [N-1:0] STIM_LAST = {N{1'b1}};

    state_t             state_q, state_d;
    logic [N-1:0]       stim_q, stim_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [VD-1:0]      vld_q, vld_d;
    logic               apply;
    logic               cap_en;
    logic               misr_clr;
    logic [SIGW-1:0]    sig;

    assign apply  = (state_q == ST_APPLY);
    // valid trails stim by CAPLAT cycles so each update sees its own vector's response
    assign cap_en = (CAPLAT == 0) ? apply : vld_q[VD-1];

    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        flush_cnt_d = flush_cnt_q;
        vld_d       = (vld_q << 1) | VD'(apply);
        misr_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    stim_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            ST_APPLY: begin
                if (stim_q == STIM_LAST) begin
                    if (CAPLAT == 0) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = CNT_W'(CAPLAT - 1);
                    end
                end else begin
                    stim_d = stim_q + N'(1);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // final MISR update lands on DONE entry, so compare one cycle later
                if (!done_q) begin
                    done_d = 1'b1;
                    pass_d = (sig == expected);
                end else if (start) begin
                    state_d  = ST_APPLY;
                    stim_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    misr_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            stim_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            flush_cnt_q <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            flush_cnt_q <= flush_cnt_d;
            vld_q       <= vld_d;
        end
    end

    la_misr #(
        .SIGW (SIGW),
        .POLY (POLY)
    ) u_misr (
        .clk    (clk),
        .nreset (nreset),
        .clr    (misr_clr),
        .en     (cap_en),
        .din    (resp),
        .sig    (sig)
    );

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig;

endmodule

// File: tb/tb_la_cellbist.sv
// Directed bench for la_cellbist: aoi221 cell swept with CAPLAT=0 and with a
// 2-stage pipelined copy (CAPLAT=2); results checked through a scoreboard.
module tb_la_cellbist;

    localparam int N    = 5;
    localparam int SIGW = 16;

    typedef struct {
        string           tag;
        logic [SIGW-1:0] sig;
        logic            pass;
        int              cyc;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic start = 1'b0;
    logic stuck = 1'b0;
    int   sel = 0;
    logic [SIGW-1:0] exp_in = '0;

    logic            start0, start2;
    logic [N-1:0]    stim0, stim2;
    logic            resp0, resp2;
    logic            busy0, busy2, done0, done2, pass0, pass2;
    logic [SIGW-1:0] sig0, sig2;
    logic            p1 = 1'b0, p2 = 1'b0;

    logic [N-1:0]    o_stim;
    logic            o_busy, o_done, o_pass;
    logic [SIGW-1:0] o_sig;

    int n_pass = 0;
    int n_total = 0;
    int ecnt = 0;
    int e0 = 0;
    int busy_cnt = 0;
    logic [SIGW-1:0] golden, stuck_sig, first_sig;

    function automatic logic aoi221(input logic [4:0] s);
        return ~((s[0] & s[1]) | (s[2] & s[3]) | s[4]);
    endfunction

    function automatic logic [SIGW-1:0] ref_sig(input bit stuck_at0);
        logic [SIGW-1:0] s;
        logic [4:0]      v;
        logic            r;
        s = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            v = 5'(i);
            r = stuck_at0 ? 1'b0 : aoi221(v);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, r};
        end
        return s;
    endfunction

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    assign start0 = start && (sel == 0);
    assign start2 = start && (sel == 2);
    assign resp0  = stuck ? 1'b0 : aoi221(stim0);
    assign resp2  = p2;

    always @(posedge clk) begin
        p1 <= aoi221(stim2);
        p2 <= p1;
    end

    always_comb begin
        o_stim = (sel == 2) ? stim2 : stim0;
        o_busy = (sel == 2) ? busy2 : busy0;
        o_done = (sel == 2) ? done2 : done0;
        o_pass = (sel == 2) ? pass2 : pass0;
        o_sig  = (sel == 2) ? sig2  : sig0;
    end

    la_cellbist #(.N(N), .CAPLAT(0), .SIGW(SIGW), .POLY(16'h1021)) dut0 (
        .clk(clk), .nreset(nreset), .start(start0), .expected(exp_in),
        .stim(stim0), .resp(resp0), .busy(busy0), .done(done0),
        .pass(pass0), .signature(sig0)
    );

    la_cellbist #(.N(N), .CAPLAT(2), .SIGW(SIGW), .POLY(16'h1021)) dut2 (
        .clk(clk), .nreset(nreset), .start(start2), .expected(exp_in),
        .stim(stim2), .resp(resp2), .busy(busy2), .done(done2),
        .pass(pass2), .signature(sig2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Called at a negedge: pulses start, queues the expected result, checks the accept cycle.
    task automatic launch(input string tag, input logic [SIGW-1:0] es, input logic ep, input int lat);
        exp_t e;
        e.tag  = tag;
        e.sig  = es;
        e.pass = ep;
        e.cyc  = (1 << N) + lat + 1;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0 = ecnt;
        busy_cnt = 1;
        check({tag, "_stim0"}, 32'(o_stim), 32'd0);
        check({tag, "_busy1"}, 32'(o_busy), 32'd1);
        check({tag, "_done0"}, 32'(o_done), 32'd0);
        check({tag, "_pass0"}, 32'(o_pass), 32'd0);
        check({tag, "_seed"},  32'(o_sig),  32'hFFFF);
    endtask

    task automatic finish(input int lat, input bit pulses, input int abort_at);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (pulses) begin
                start = ((ecnt - e0) == 5) || ((ecnt - e0) == 20);
                if ((ecnt - e0) == 21) check("t4_stim_counting", 32'(o_stim), 32'd21);
            end
            if (abort_at >= 0 && o_busy && (32'(o_stim) == 32'(abort_at))) begin
                nreset = 1'b0;
                @(negedge clk);
                nreset = 1'b1;
                check("abort_stim", 32'(o_stim), 32'd0);
                check("abort_busy", 32'(o_busy), 32'd0);
                check("abort_done", 32'(o_done), 32'd0);
                check("abort_pass", 32'(o_pass), 32'd0);
                check("abort_sig",  32'(o_sig),  32'hFFFF);
                e = sb.pop_front();
                return;
            end
            if (o_done) begin
                seen = 1'b1;
                e = sb.pop_front();
                check({e.tag, "_done_cycle"}, 32'(ecnt - e0), 32'(e.cyc));
                check({e.tag, "_pass"},       32'(o_pass),    32'(e.pass));
                check({e.tag, "_sig"},        32'(o_sig),     32'(e.sig));
                check({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'((1 << N) + lat));
                check({e.tag, "_stim_hold"},  32'(o_stim),    32'd31);
            end else if (o_busy) begin
                busy_cnt++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) e = sb.pop_front();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        golden    = ref_sig(1'b0);
        stuck_sig = ref_sig(1'b1);
        exp_in    = golden;

        nreset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stim", 32'(stim0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pass", 32'(pass0), 32'd0);
        check("rst_sig0", 32'(sig0),  32'hFFFF);
        check("rst_sig2", 32'(sig2),  32'hFFFF);
        nreset = 1'b1;
        @(negedge clk);

        // T1: clean sweep, combinational cell
        sel = 0;
        @(negedge clk);
        launch("t1", golden, 1'b1, 0);
        finish(0, 1'b0, -1);
        first_sig = sig0;

        // T6: restart on the cycle done is first seen
        launch("t6", first_sig, 1'b1, 0);
        finish(0, 1'b0, -1);

        // T2: stuck-at-0 cell output
        stuck = 1'b1;
        launch("t2", stuck_sig, 1'b0, 0);
        finish(0, 1'b0, -1);
        check("t2_sig_differs", 32'(sig0 != golden), 32'd1);
        stuck = 1'b0;

        // T4: start pulses while busy are ignored
        launch("t4", golden, 1'b1, 0);
        finish(0, 1'b1, -1);

        // T5: abort at stim=10, then a clean sweep
        launch("t5a", golden, 1'b1, 0);
        finish(0, 1'b0, 10);
        @(negedge clk);
        launch("t5b", golden, 1'b1, 0);
        finish(0, 1'b0, -1);

        // reset and start on the same edge: reset wins
        nreset = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        nreset = 1'b1;
        check("rst_vs_start_busy", 32'(busy0), 32'd0);
        check("rst_vs_start_stim", 32'(stim0), 32'd0);
        check("rst_vs_start_done", 32'(done0), 32'd0);
        @(negedge clk);
        check("rst_vs_start_idle", 32'(busy0), 32'd0);

        // T3: pipelined cell, CAPLAT=2
        sel = 2;
        @(negedge clk);
        launch("t3", golden, 1'b1, 2);
        finish(2, 1'b0, -1);
        check("t3_sig_matches_t1", 32'(sig2), 32'(first_sig));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
